mac_job_arbiter: RTL and testbench
==================================

// Module: mac_job_arbiter
// PURPOSE
//  Shares one part2_mac (signed 8x8 MAC, 16-bit accumulator f) between two requesters.
//  Each requester streams one dot-product job as a/b beats closed by a 'last' flag.
//  Jobs are granted whole and round-robin; the accumulator is cleared before each job.
//  The final f is returned on a result port tagged with requester id and beat count.
// PARAMETERS
//  LEN_W    8   width of the beat counter / res_len; saturates at 2**LEN_W-1
//  OUTS_W   3   width of the in-flight counter; must hold MAC pipeline depth + 1
// PORTS
//  clk            in   1       single clock, all logic rising-edge
//  reset          in   1       asynchronous, active-high
//  req0_valid     in   1       requester 0 beat valid
//  req0_ready     out  1       requester 0 beat accepted when valid&ready
//  req0_a,req0_b  in   8 each  signed operands
//  req0_last      in   1       final beat of the job
//  req1_*         --   --      identical set for requester 1
//  res_valid      out  1       result available; held until res_ready
//  res_ready      in   1       result consumer ready
//  res_f          out  16      signed final accumulator value
//  res_id         out  1       requester that owned the job
//  res_len        out  LEN_W   beats in the job (saturating)
//  res_ovf        out  1       beat count saturated (job longer than 2**LEN_W-1)
//  mac_reset      out  1       drives MAC reset (clears accumulator)
//  mac_a,mac_b    out  8 each  registered operands to MAC
//  mac_valid_in   out  1       registered beat strobe to MAC
//  mac_valid_out  in   1       MAC result strobe
//  mac_f          in   16      MAC accumulator
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, req*_ready=0, res_valid=0, res_f=0, res_id=0,
//   res_len=0, res_ovf=0, mac_a=mac_b=0, mac_valid_in=0. mac_reset=reset|(state==CLEAR),
//   so reset is forwarded combinationally.
//  FSM IDLE->CLEAR->STREAM->DRAIN->DONE->IDLE:
//  IDLE: if any reqk_valid, grant = pointer if pointer valid else the other; go CLEAR.
//   Beats are NOT consumed in IDLE.
//  CLEAR: exactly 1 cycle; mac_reset=1; clear beat count, ovf and in-flight count.
//  STREAM: req_ready=1 for granted requester only, 0 for the other.
//   A beat accepted on edge t drives mac_a/b=beat and mac_valid_in=1 during cycle t+1.
//   Otherwise mac_valid_in=0 and mac_a/b hold.
//   Beat count +1 per accepted beat, saturating; ovf set on the saturating beat.
//   Accepting the last beat deasserts ready the next cycle and enters DRAIN.
//  In-flight count: +1 on mac_valid_in, -1 on mac_valid_out; both same cycle = no change.
//  DRAIN: wait until in-flight==0 and no mac_valid_in pending.
//   Latch mac_f on every mac_valid_out; the last latched value is res_f.
//   A mac_valid_out seen with in-flight==0 is ignored (no underflow).
//  DONE: res_valid=1; res_f/id/len/ovf stable; leave on res_valid&res_ready.
//   Then pointer = ~grant (pointer moves to the other requester) and go IDLE.
//  Simultaneous requests alternate strictly; a lone requester may win back-to-back.
//  Non-granted requester waits with valid high; its beats and order are untouched.
//  Reset mid-job: job discarded immediately, accumulator cleared, no result emitted.
//  Arithmetic is done by the MAC; res_f is mac_f unchanged, wrap per MAC.
// TESTING
//  (Bench drives MAC model with 1-cycle valid latency and f += a*b.)
//  1 req0 beats (3,4),(-2,5),(7,7,last) -> one res: f=51, id=0, len=3, ovf=0.
//  2 req0 and req1 valid in same IDLE cycle after reset -> req0 served first;
//    req1 next; req1 ready=0 throughout job 0.
//  3 req1 (-128,-128)x2 last -> res_f=32768 wrapped = -32768 (16'h8000), id=1, len=2.
//  4 res_ready held 0 for 10 cycles -> res_valid and fields stable; no new grant until handshake.
//  5 reset asserted mid-STREAM of req0 -> outputs at reset values same cycle;
//    next job result excludes prior beats.
//  6 LEN_W=2, 4-beat job of (1,1) -> res_len=3, res_ovf=1, res_f=4.

Source files
------------

// File: rtl/mac_job_arbiter.sv
// Two-requester, whole-job round-robin front end for a shared signed 8x8 MAC.
// Each job clears the accumulator, streams its beats, drains the MAC, then reports.
module mac_job_arbiter #(
    parameter int LEN_W  = 8,
    parameter int OUTS_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic             req0_last,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    input  logic             req1_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_f,
    output logic             res_id,
    output logic [LEN_W-1:0] res_len,
    output logic             res_ovf,
    output logic             mac_reset,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    output logic             mac_valid_in,
    input  logic             mac_valid_out,
    input  logic [15:0]      mac_f
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_n;
    logic ptr, grant, grant_n;
    logic [OUTS_W-1:0] outs;
    logic sel_valid, sel_last, accept;
    logic [7:0] sel_a, sel_b;

    always_comb begin
        sel_valid = grant ? req1_valid : req0_valid;
        sel_last  = grant ? req1_last  : req0_last;
        sel_a     = grant ? req1_a     : req0_a;
        sel_b     = grant ? req1_b     : req0_b;
    end

    assign accept     = (state == STREAM) && sel_valid;
    assign req0_ready = (state == STREAM) && !grant;
    assign req1_ready = (state == STREAM) && grant;
    assign res_valid  = (state == DONE);
    assign res_id     = grant;
    assign mac_reset  = reset | (state == CLEAR);

    always_comb begin
        state_n = state;
        grant_n = grant;
        unique case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // pointer side wins if asking, else the other side
                    grant_n = ptr ? req1_valid : !req0_valid;
                    state_n = CLEAR;
                end
            end
            CLEAR:  state_n = STREAM;
            STREAM: if (accept && sel_last) state_n = DRAIN;
            DRAIN:  if (outs == '0 && !mac_valid_in) state_n = DONE;
            DONE:   if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= 1'b0;
            ptr   <= 1'b0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            if (state == DONE && res_ready) ptr <= ~grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_a        <= '0;
            mac_b        <= '0;
            mac_valid_in <= 1'b0;
            res_len      <= '0;
            res_ovf      <= 1'b0;
            res_f        <= '0;
            outs         <= '0;
        end else begin
            mac_valid_in <= accept;
            if (accept) begin
                mac_a <= sel_a;
                mac_b <= sel_b;
            end
            if (state == CLEAR) begin
                res_len <= '0;
                res_ovf <= 1'b0;
                outs    <= '0;
            end else begin
                if (accept) begin
                    if (&res_len) res_ovf <= 1'b1;
                    else res_len <= res_len + 1'b1;
                end
                // a result strobe with nothing in flight is stray
                if (mac_valid_in && !mac_valid_out)
                    outs <= outs + 1'b1;
                else if (!mac_valid_in && mac_valid_out && outs != '0)
                    outs <= outs - 1'b1;
            end
            if (mac_valid_out && outs != '0 &&
                (state == STREAM || state == DRAIN))
                res_f <= mac_f;
        end
    end

endmodule

// File: tb/tb_mac_job_arbiter.sv
// Scoreboard bench for mac_job_arbiter with a 1-cycle MAC model per instance.
module tb_mac_job_arbiter;

    typedef struct packed {
        logic [15:0] f;
        logic        id;
        logic [7:0]  len;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic r0v, r0r, r0l, r1v, r1r, r1l;
    logic [7:0] r0a, r0b, r1a, r1b;
    logic res_valid, res_ready, res_id, res_ovf;
    logic [15:0] res_f;
    logic [7:0] res_len;
    logic mac_reset, mac_vin, mac_vout;
    logic [7:0] mac_a, mac_b;
    logic [15:0] mac_f;

    logic b_r0v, b_r0r, b_r0l, b_r1v, b_r1r, b_r1l;
    logic [7:0] b_r0a, b_r0b, b_r1a, b_r1b;
    logic b_res_valid, b_res_id, b_res_ovf;
    logic [15:0] b_res_f;
    logic [1:0] b_res_len;
    logic b_mac_reset, b_mac_vin, b_mac_vout;
    logic [7:0] b_mac_a, b_mac_b;
    logic [15:0] b_mac_f;

    exp_t q[$];
    exp_t q2[$];
    int total = 0;
    int bad = 0;

    logic [7:0] A0[8], B0[8], A1[8], B1[8];

    always #5 clk = ~clk;

    mac_job_arbiter #(.LEN_W(8), .OUTS_W(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a),
        .req0_b(r0b), .req0_last(r0l),
        .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a),
        .req1_b(r1b), .req1_last(r1l),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_f(res_f), .res_id(res_id), .res_len(res_len),
        .res_ovf(res_ovf), .mac_reset(mac_reset),
        .mac_a(mac_a), .mac_b(mac_b), .mac_valid_in(mac_vin),
        .mac_valid_out(mac_vout), .mac_f(mac_f)
    );

    mac_job_arbiter #(.LEN_W(2), .OUTS_W(3)) dut_b (
        .clk(clk), .reset(reset),
        .req0_valid(b_r0v), .req0_ready(b_r0r), .req0_a(b_r0a),
        .req0_b(b_r0b), .req0_last(b_r0l),
        .req1_valid(b_r1v), .req1_ready(b_r1r), .req1_a(b_r1a),
        .req1_b(b_r1b), .req1_last(b_r1l),
        .res_valid(b_res_valid), .res_ready(res_ready),
        .res_f(b_res_f), .res_id(b_res_id), .res_len(b_res_len),
        .res_ovf(b_res_ovf), .mac_reset(b_mac_reset),
        .mac_a(b_mac_a), .mac_b(b_mac_b), .mac_valid_in(b_mac_vin),
        .mac_valid_out(b_mac_vout), .mac_f(b_mac_f)
    );

    logic signed [15:0] ea, eb, prod, b_ea, b_eb, b_prod;
    assign ea     = {{8{mac_a[7]}}, mac_a};
    assign eb     = {{8{mac_b[7]}}, mac_b};
    assign prod   = ea * eb;
    assign b_ea   = {{8{b_mac_a[7]}}, b_mac_a};
    assign b_eb   = {{8{b_mac_b[7]}}, b_mac_b};
    assign b_prod = b_ea * b_eb;

    always @(posedge clk or posedge mac_reset) begin
        if (mac_reset) begin
            mac_f    <= '0;
            mac_vout <= 1'b0;
        end else begin
            mac_vout <= mac_vin;
            if (mac_vin) mac_f <= mac_f + prod;
        end
    end

    always @(posedge clk or posedge b_mac_reset) begin
        if (b_mac_reset) begin
            b_mac_f    <= '0;
            b_mac_vout <= 1'b0;
        end else begin
            b_mac_vout <= b_mac_vin;
            if (b_mac_vin) b_mac_f <= b_mac_f + b_prod;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && res_valid && res_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL res_unexpected got f=%h id=%0d want none",
                         res_f, res_id);
            end else begin
                e = q.pop_front();
                if ({res_f, res_id, res_len, res_ovf} !== e) begin
                    bad++;
                    $display("FAIL result got f=%h id=%0d len=%0d ovf=%0d want f=%h id=%0d len=%0d ovf=%0d",
                             res_f, res_id, res_len, res_ovf,
                             e.f, e.id, e.len, e.ovf);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && b_res_valid && res_ready) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL b_res_unexpected got f=%h want none", b_res_f);
            end else begin
                e = q2.pop_front();
                if ({b_res_f, b_res_id, 6'b0, b_res_len, b_res_ovf} !== e) begin
                    bad++;
                    $display("FAIL b_result got f=%h id=%0d len=%0d ovf=%0d want f=%h id=%0d len=%0d ovf=%0d",
                             b_res_f, b_res_id, b_res_len, b_res_ovf,
                             e.f, e.id, e.len, e.ovf);
                end
            end
        end
    end

    function automatic exp_t calc(input bit k, input int n,
                                  input logic [7:0] as[8],
                                  input logic [7:0] bs[8],
                                  input int maxlen);
        exp_t e;
        logic [15:0] f;
        logic signed [15:0] x, y;
        f = '0;
        for (int i = 0; i < n; i++) begin
            x = {{8{as[i][7]}}, as[i]};
            y = {{8{bs[i][7]}}, bs[i]};
            f = f + x * y;
        end
        e.f   = f;
        e.id  = k;
        e.len = (n > maxlen) ? 8'(maxlen) : 8'(n);
        e.ovf = (n > maxlen);
        return e;
    endfunction

    task automatic run_job(input bit k, input int n,
                           input logic [7:0] as[8],
                           input logic [7:0] bs[8]);
        for (int i = 0; i < n; i++) begin
            int c = 0;
            if (k) begin
                r1v = 1; r1a = as[i]; r1b = bs[i]; r1l = (i == n - 1);
            end else begin
                r0v = 1; r0a = as[i]; r0b = bs[i]; r0l = (i == n - 1);
            end
            @(negedge clk);
            while (!(k ? r1r : r0r) && c < 200) begin
                @(negedge clk);
                c++;
            end
            if (c >= 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout req%0d got=no-ready want=ready", k);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (k) begin r1v = 0; r1l = 0; end
        else begin r0v = 0; r0l = 0; end
    endtask

    task automatic run_job_b(input int n, input logic [7:0] as[8],
                             input logic [7:0] bs[8]);
        for (int i = 0; i < n; i++) begin
            int c = 0;
            b_r0v = 1; b_r0a = as[i]; b_r0b = bs[i]; b_r0l = (i == n - 1);
            @(negedge clk);
            while (!b_r0r && c < 200) begin
                @(negedge clk);
                c++;
            end
            if (c >= 200) begin
                total++;
                bad++;
                $display("FAIL b_accept_timeout got=no-ready want=ready");
                break;
            end
            @(posedge clk);
            #1;
        end
        b_r0v = 0;
        b_r0l = 0;
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((q.size() != 0 || q2.size() != 0) && c < 300) begin
            @(negedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        total++;
        if (q.size() != 0 || q2.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got pending=%0d want 0",
                     q.size() + q2.size());
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({r0r, r1r, res_valid, res_f, res_id, res_len, res_ovf,
             mac_a, mac_b, mac_vin} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got r0r=%b r1r=%b rv=%b f=%h len=%0d ma=%h mvi=%b want all 0",
                     r0r, r1r, res_valid, res_f, res_len, mac_a, mac_vin);
        end
        total++;
        if (mac_reset !== 1'b1) begin
            bad++;
            $display("FAIL reset_mac_reset got=%b want=1", mac_reset);
        end
        @(negedge clk);
        reset = 0;
        #1;
        total++;
        if (mac_reset !== 1'b0) begin
            bad++;
            $display("FAIL idle_mac_reset got=%b want=0", mac_reset);
        end
    endtask

    task automatic test_single();
        A0 = '{8'd3, 8'hFE, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        B0 = '{8'd4, 8'd5, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        q.push_back(calc(0, 3, A0, B0, 255));
        run_job(0, 3, A0, B0);
        wait_drain();
    endtask

    task automatic test_rr();
        bit viol = 0;
        pulse_reset();
        A0 = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        B0 = '{8'd10, 8'd10, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        A1 = '{8'hFF, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        B1 = '{8'd20, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        q.push_back(calc(0, 3, A0, B0, 255));
        q.push_back(calc(1, 2, A1, B1, 255));
        fork
            run_job(0, 3, A0, B0);
            run_job(1, 2, A1, B1);
            begin
                int c = 0;
                while (q.size() == 2 && c < 300) begin
                    @(negedge clk);
                    if (r1r) viol = 1;
                    c++;
                end
            end
        join
        wait_drain();
        total++;
        if (viol !== 1'b0) begin
            bad++;
            $display("FAIL rr_req1_ready_during_job0 got=%b want=0", viol);
        end
    endtask

    task automatic test_wrap();
        A1 = '{8'h80, 8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        B1 = '{8'h80, 8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        q.push_back(calc(1, 2, A1, B1, 255));
        run_job(1, 2, A1, B1);
        wait_drain();
    endtask

    task automatic test_hold();
        int c = 0;
        int errs = 0;
        res_ready = 0;
        A0 = '{8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        B0 = '{8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        A1 = '{8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        B1 = '{8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        q.push_back(calc(0, 1, A0, B0, 255));
        q.push_back(calc(1, 1, A1, B1, 255));
        run_job(0, 1, A0, B0);
        while (!res_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        fork
            run_job(1, 1, A1, B1);
        join_none
        repeat (10) begin
            @(negedge clk);
            if ({res_valid, res_f, res_id, res_len, res_ovf, r0r, r1r} !==
                {1'b1, 16'd6, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0})
                errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL hold_stable got bad_cycles=%0d f=%h rv=%b r1r=%b want 0",
                     errs, res_f, res_valid, r1r);
        end
        res_ready = 1;
        wait fork;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        int c = 0;
        r0v = 1; r0a = 8'd5; r0b = 8'd5; r0l = 0;
        while (acc < 2 && c < 100) begin
            @(negedge clk);
            if (r0r) acc++;
            c++;
        end
        @(posedge clk);
        #1;
        reset = 1;
        #1;
        total++;
        if ({r0r, r1r, mac_vin, res_valid, mac_a, mac_b, mac_f} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got r0r=%b mvi=%b rv=%b ma=%h f=%h want 0",
                     r0r, mac_vin, res_valid, mac_a, mac_f);
        end
        total++;
        if (mac_reset !== 1'b1) begin
            bad++;
            $display("FAIL midreset_mac_reset got=%b want=1", mac_reset);
        end
        r0v = 0;
        @(negedge clk);
        reset = 0;
        A0 = '{8'd1, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        B0 = '{8'd2, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        q.push_back(calc(0, 2, A0, B0, 255));
        run_job(0, 2, A0, B0);
        wait_drain();
    endtask

    task automatic test_sat();
        A0 = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        B0 = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        q2.push_back(calc(0, 4, A0, B0, 3));
        run_job_b(4, A0, B0);
        wait_drain();
        q2.push_back(calc(0, 3, A0, B0, 3));
        run_job_b(3, A0, B0);
        wait_drain();
    endtask

    initial begin
        reset = 1; res_ready = 1;
        r0v = 0; r0a = 0; r0b = 0; r0l = 0;
        r1v = 0; r1a = 0; r1b = 0; r1l = 0;
        b_r0v = 0; b_r0a = 0; b_r0b = 0; b_r0l = 0;
        b_r1v = 0; b_r1a = 0; b_r1b = 0; b_r1l = 0;
        test_reset();
        test_single();
        test_rr();
        test_wrap();
        test_hold();
        test_reset_mid();
        test_sat();
        total++;
        if (q.size() + q2.size() != 0) begin
            bad++;
            $display("FAIL final_queue got=%0d want=0", q.size() + q2.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
